cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, data word width.
REQ-002 The block SHALL have parameter AWIDTH, default 16, byte address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 icache_miss  input  1  I-cache miss pending; held until fill completes.
REQ-006 icache_miss_addr  input  AWIDTH  I-cache missing byte address.
REQ-007 dcache_miss  input  1  D-cache miss pending; held until fill completes.
REQ-008 dcache_miss_addr  input  AWIDTH  D-cache missing byte address.
REQ-009 st_req  input  1  write-through store request; held until st_ack.
REQ-010 st_addr / st_data  input  AWIDTH / DWIDTH  store address and data.
REQ-011 mem_addr / mem_data_in  output  AWIDTH / DWIDTH  address and write data to main memory.
REQ-012 mem_en / mem_wr  output  1 / 1  main memory enable and write strobe.
REQ-013 mem_data_out / mem_data_valid  input  DWIDTH / 1  main memory read data and valid.
REQ-014 fill_addr / fill_data  output  AWIDTH / DWIDTH  word address and data being written into the filled cache.
REQ-015 icache_data_wen, icache_tag_wen, dcache_data_wen, dcache_tag_wen  output  1 each  cache array write enables.
REQ-016 st_ack  output  1  one-cycle pulse, store issued to memory.
REQ-017 icache_busy / dcache_busy  output  1 / 1  fill in progress for that cache.

Function
REQ-018 States SHALL be IDLE, STORE, FILL_I, FILL_D; only IDLE accepts new requests.
REQ-019 IDLE priority SHALL be: st_req -> STORE, else dcache_miss -> FILL_D, else icache_miss -> FILL_I; exception: if the last completed fill was FILL_D and icache_miss is pending, FILL_I wins over dcache_miss.
REQ-020 STORE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr=st_addr, mem_data_in=st_data, st_ack=1; next state IDLE.
REQ-021 On fill entry, the block SHALL latch base = miss_addr & ~(AWIDTH)'hF; a block is 8 words, 16 bytes.
REQ-022 Issue phase: 3-bit issue counter 0..7; each cycle mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt; 8 consecutive cycles, then mem_en=0.
REQ-023 Receive phase, overlapping issue: 3-bit recv counter; each cycle with mem_data_valid=1, the block SHALL assert the target cache data_wen with fill_addr=base+2*recv_cnt and fill_data=mem_data_out, then increment recv_cnt.
REQ-024 The block SHALL count beats by mem_data_valid only, never by a fixed latency; valid cycles in IDLE/STORE SHALL be ignored.
REQ-025 On the 8th valid beat, target tag_wen SHALL assert in the same cycle as the final data_wen; state returns to IDLE next cycle.
REQ-026 busy for the target cache SHALL be 1 from the cycle after grant through the tag_wen cycle inclusive.
REQ-027 Only the granted cache's wen signals SHALL ever assert; at most one data_wen and one tag_wen per cycle.
REQ-028 Address arithmetic SHALL wrap modulo 2^AWIDTH; base 0xFFF0 issues 0xFFF0..0xFFFE.
REQ-029 A request arriving while not IDLE SHALL wait; misses/stores are never dropped and are serviced in a later IDLE cycle per REQ-019.
REQ-030 Outputs not driven by the current state SHALL be 0.

Reset
REQ-031 While rst=0: state IDLE, counters 0, last-fill flag = FILL_I, all outputs 0.
REQ-032 Reset asserted mid-fill SHALL abort it immediately with no tag_wen; after release, a still-held miss starts a fresh fill from word 0.

Verification
REQ-033 D miss at 0x1234, latency 4 -> addresses 0x1230..0x123E on cycles 1-8; dcache_data_wen on 8 valid beats; dcache_tag_wen with beat 8; dcache_busy falls after.
REQ-034 icache_miss and dcache_miss raised together -> FILL_D first, then FILL_I; second tie after FILL_D -> FILL_I.
REQ-035 st_req (0x0040, 0xBEEF) during FILL_I -> no mem_wr until fill ends; then one cycle mem_wr=1, addr 0x0040, data 0xBEEF, st_ack=1.
REQ-036 Irregular mem_data_valid gaps -> exactly 8 data_wen, fill_addr strictly sequential, tag_wen only on the 8th.
REQ-037 rst=0 after 3 fill beats -> outputs 0 at once, no tag_wen; held miss refills from base+0 after release.
REQ-038 Miss at 0xFFFA -> addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and write-through stores onto one main-memory port.
// Fills issue 8 word reads back to back and write the returned beats into the target cache.
module cache_mem_arbiter #(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_miss,
   input  logic [AWIDTH-1:0] icache_miss_addr,
   input  logic              dcache_miss,
   input  logic [AWIDTH-1:0] dcache_miss_addr,
   input  logic              st_req,
   input  logic [AWIDTH-1:0] st_addr,
   input  logic [DWIDTH-1:0] st_data,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_data_in,
   output logic              mem_en,
   output logic              mem_wr,
   input  logic [DWIDTH-1:0] mem_data_out,
   input  logic              mem_data_valid,
   output logic [AWIDTH-1:0] fill_addr,
   output logic [DWIDTH-1:0] fill_data,
   output logic              icache_data_wen,
   output logic              icache_tag_wen,
   output logic              dcache_data_wen,
   output logic              dcache_tag_wen,
   output logic              st_ack,
   output logic              icache_busy,
   output logic              dcache_busy
);

   localparam logic [AWIDTH-1:0] BLK_MASK = ~(AWIDTH'(4'hF));

   typedef enum logic [1:0] {IDLE, STORE, FILL_I, FILL_D} state_t;

   state_t            state_q, state_d;
   logic [2:0]        issue_cnt_q, issue_cnt_d;
   logic              issue_done_q, issue_done_d;
   logic [2:0]        recv_cnt_q, recv_cnt_d;
   logic [AWIDTH-1:0] base_q, base_d;
   logic              last_fill_d_q, last_fill_d_d;

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         issue_cnt_q   <= 3'd0;
         issue_done_q  <= 1'b0;
         recv_cnt_q    <= 3'd0;
         base_q        <= '0;
         last_fill_d_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         issue_cnt_q   <= issue_cnt_d;
         issue_done_q  <= issue_done_d;
         recv_cnt_q    <= recv_cnt_d;
         base_q        <= base_d;
         last_fill_d_q <= last_fill_d_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d         = state_q;
      issue_cnt_d     = issue_cnt_q;
      issue_done_d    = issue_done_q;
      recv_cnt_d      = recv_cnt_q;
      base_d          = base_q;
      last_fill_d_d   = last_fill_d_q;
      mem_addr        = '0;
      mem_data_in     = '0;
      mem_en          = 1'b0;
      mem_wr          = 1'b0;
      fill_addr       = '0;
      fill_data       = '0;
      icache_data_wen = 1'b0;
      icache_tag_wen  = 1'b0;
      dcache_data_wen = 1'b0;
      dcache_tag_wen  = 1'b0;
      st_ack          = 1'b0;
      icache_busy     = 1'b0;
      dcache_busy     = 1'b0;

      case (state_q)
         IDLE: begin
            issue_cnt_d  = 3'd0;
            issue_done_d = 1'b0;
            recv_cnt_d   = 3'd0;
            // After a D fill a waiting I miss goes first so neither side starves
            if (st_req) begin
               state_d = STORE;
            end else if (icache_miss && (last_fill_d_q || !dcache_miss)) begin
               state_d = FILL_I;
               base_d  = icache_miss_addr & BLK_MASK;
            end else if (dcache_miss) begin
               state_d = FILL_D;
               base_d  = dcache_miss_addr & BLK_MASK;
            end
         end

         STORE: begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = st_addr;
            mem_data_in = st_data;
            st_ack      = 1'b1;
            state_d     = IDLE;
         end

         FILL_I, FILL_D: begin
            icache_busy = (state_q == FILL_I);
            dcache_busy = (state_q == FILL_D);
            if (!issue_done_q) begin
               mem_en      = 1'b1;
               mem_addr    = base_q + AWIDTH'({issue_cnt_q, 1'b0});
               issue_cnt_d = issue_cnt_q + 3'd1;
               if (issue_cnt_q == 3'd7) issue_done_d = 1'b1;
            end
            // Beats are counted on valid only; memory latency may vary per beat
            if (mem_data_valid) begin
               fill_addr       = base_q + AWIDTH'({recv_cnt_q, 1'b0});
               fill_data       = mem_data_out;
               recv_cnt_d      = recv_cnt_q + 3'd1;
               icache_data_wen = (state_q == FILL_I);
               dcache_data_wen = (state_q == FILL_D);
               if (recv_cnt_q == 3'd7) begin
                  icache_tag_wen = (state_q == FILL_I);
                  dcache_tag_wen = (state_q == FILL_D);
                  last_fill_d_d  = (state_q == FILL_D);
                  state_d        = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule
